// File: rtl/seq_mult_core.sv
// Sequential shift-and-add multiplier: sign-magnitude core with optional early termination
// when the remaining multiplier bits are all zero.
module seq_mult_core #(
  parameter int DW         = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode_signed,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic            busy,
  output logic            ready,
  output logic [2*DW-1:0] product,
  output logic [1:0]      o_state_dbg
);

  // Handshake: start is taken only in IDLE (ignored while busy); busy covers RUN and FIX;
  // ready is a one-cycle pulse and product stays valid from that cycle until the next completion.
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2*DW-1:0]   r_mcand;
  logic [DW-1:0]     r_mplier;
  logic [2*DW-1:0]   r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_sign;
  logic              r_ready;
  logic [2*DW-1:0]   r_product;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [DW-1:0]     w_a_mag;
  logic [DW-1:0]     w_b_mag;
  logic              w_last;

  // -2^(DW-1) negates to itself, which read unsigned is exactly its magnitude.
  assign w_a_neg = mode_signed & multiplicand[DW-1];
  assign w_b_neg = mode_signed & multiplier[DW-1];
  assign w_a_mag = w_a_neg ? (~multiplicand + DW'(1)) : multiplicand;
  assign w_b_mag = w_b_neg ? (~multiplier + DW'(1)) : multiplier;

  // Early termination stops once no set bits remain above the current LSB.
  assign w_last = (EARLY_TERM != 0) ? (r_mplier[DW-1:1] == '0)
                                    : (r_cnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_ready   <= 1'b0;
      r_product <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{DW{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_sign   <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        S_FIX: begin
          // Negating a zero accumulator gives zero, so no negative zero can appear.
          r_product <= r_sign ? (-r_acc) : r_acc;
          r_ready   <= 1'b1;
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign ready       = r_ready;
  assign product     = r_product;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_seq_mult_core.sv
// Bench for seq_mult_core at DW=8: one instance without and one with early termination,
// sharing operands and reset, each with its own start and expected-result queue.
module tb_seq_mult_core;

  logic        clk;
  logic        rst;
  logic        start_0, start_1;
  logic        mode_signed;
  logic [7:0]  multiplicand, multiplier;
  logic        busy_0, busy_1, ready_0, ready_1;
  logic [15:0] product_0, product_1;
  logic [1:0]  state_0, state_1;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int n_vec = 0;
  int n_err = 0;

  seq_mult_core #(.DW(8), .EARLY_TERM(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_0), .mode_signed(mode_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy_0), .ready(ready_0), .product(product_0), .o_state_dbg(state_0)
  );

  seq_mult_core #(.DW(8), .EARLY_TERM(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_1), .mode_signed(mode_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy_1), .ready(ready_1), .product(product_1), .o_state_dbg(state_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_prod(input bit m, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa, xb;
    xa = m ? {{8{a[7]}}, a} : {8'h00, a};
    xb = m ? {{8{b[7]}}, b} : {8'h00, b};
    return xa * xb;
  endfunction

  function automatic int model_n(input bit et, input bit m, input logic [7:0] b);
    logic [7:0] mb;
    int n;
    if (!et) return 8;
    mb = (m && b[7]) ? (8'h00 - b) : b;
    n = 1;
    for (int i = 0; i < 8; i++) if (mb[i]) n = i + 1;
    return n;
  endfunction

  // Called just after a negedge. Latency counts edges after the accepting edge.
  task automatic run_op(input bit sel, input bit m, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input int exp_lat, input string name);
    int lat, bsy;
    logic [15:0] exp_v, got;
    if (sel) exp_q1.push_back(exp_p); else exp_q0.push_back(exp_p);
    mode_signed = m; multiplicand = a; multiplier = b;
    if (sel) start_1 = 1'b1; else start_0 = 1'b1;
    @(negedge clk);
    start_0 = 1'b0; start_1 = 1'b0;
    lat = 0; bsy = 0;
    while (!(sel ? ready_1 : ready_0) && lat < 40) begin
      if (sel ? busy_1 : busy_0) bsy++;
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat >= 40) begin
      n_err++;
      $display("FAIL %s timeout: no ready after %0d cycles, required at %0d", name, lat, exp_lat);
      if (sel) exp_q1.delete(); else exp_q0.delete();
      return;
    end
    got = sel ? product_1 : product_0;
    if (sel ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
      n_err++;
      $display("FAIL %s product: ready with empty queue, got %h", name, got);
    end else begin
      exp_v = sel ? exp_q1.pop_front() : exp_q0.pop_front();
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL %s product: got %h required %h", name, got, exp_v);
      end
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (bsy !== exp_lat) begin
      n_err++;
      $display("FAIL %s busy cycles: got %0d required %0d", name, bsy, exp_lat);
    end
    @(negedge clk);
    n_vec++;
    if ((sel ? ready_1 : ready_0) !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready pulse width: got ready=1 second cycle, required 0", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_0 = 0; start_1 = 0; mode_signed = 0; multiplicand = 0; multiplier = 0;
    @(negedge clk);
    n_vec++;
    if ({busy_0, ready_0, product_0, state_0} !== 20'h0) begin
      n_err++;
      $display("FAIL reset dut0: busy=%b ready=%b product=%h state=%0d, required all 0",
               busy_0, ready_0, product_0, state_0);
    end
    n_vec++;
    if ({busy_1, ready_1, product_1, state_1} !== 20'h0) begin
      n_err++;
      $display("FAIL reset dut1: busy=%b ready=%b product=%h state=%0d, required all 0",
               busy_1, ready_1, product_1, state_1);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_width();
    run_op(0, 0, 8'hFF, 8'hFF, 16'hFE01, 9, "u255x255");
    run_op(0, 1, 8'h80, 8'h80, 16'h4000, 9, "s-128x-128");
    run_op(0, 1, 8'h80, 8'h7F, 16'hC080, 9, "s-128x127");
    run_op(0, 0, 8'h80, 8'h80, 16'h4000, 9, "u128x128");
    run_op(1, 1, 8'h80, 8'h80, 16'h4000, 9, "et_s-128x-128");
  endtask

  task automatic test_early_term();
    run_op(1, 1, 8'hFD, 8'h05, 16'hFFF1, 4, "et_s-3x5");
    run_op(1, 1, 8'd77, 8'h00, 16'h0000, 2, "et_s77x0");
    run_op(1, 1, 8'h00, 8'hFB, 16'h0000, 4, "et_s0x-5_negzero");
    run_op(1, 0, 8'hFF, 8'h01, 16'h00FF, 2, "et_u255x1");
  endtask

  task automatic test_random();
    bit sel, m;
    logic [7:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sel = i[0];
      m   = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) b = ~b;
      run_op(sel, m, a, b, model_prod(m, a, b), model_n(sel, m, b) + 1, "random");
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    exp_q0.push_back(16'h0258);
    mode_signed = 0; multiplicand = 8'd200; multiplier = 8'd3; start_0 = 1'b1;
    @(negedge clk);
    start_0 = 1'b0;
    lat = 0;
    while (!ready_0 && lat < 40) begin
      if (lat == 2) begin
        start_0 = 1'b1; mode_signed = 1; multiplicand = 8'h81; multiplier = 8'hFF;
      end else begin
        start_0 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_0 = 1'b0;
    n_vec++;
    if (lat >= 40 || exp_q0.size() == 0) begin
      n_err++;
      $display("FAIL ignore_start timeout: no ready after %0d cycles", lat);
    end else if (product_0 !== exp_q0[0] || lat !== 9) begin
      n_err++;
      $display("FAIL ignore_start: got product %h latency %0d, required %h latency 9",
               product_0, lat, exp_q0[0]);
    end
    if (exp_q0.size() != 0) void'(exp_q0.pop_front());
    @(negedge clk);
    n_vec++;
    if (busy_0 !== 1'b0 || ready_0 !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start aftermath: busy=%b ready=%b, required 0 0", busy_0, ready_0);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp_v;
    exp_q1.push_back(16'hFFF1);
    exp_q1.push_back(16'h0078);
    mode_signed = 1; multiplicand = 8'hFD; multiplier = 8'h05; start_1 = 1'b1;
    @(negedge clk);
    mode_signed = 0; multiplicand = 8'd12; multiplier = 8'd10;
    lat = 0;
    while (!ready_1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_v = (exp_q1.size() != 0) ? exp_q1.pop_front() : 16'hxxxx;
    n_vec++;
    if (product_1 !== exp_v || lat !== 4) begin
      n_err++;
      $display("FAIL b2b first: got product %h latency %0d, required %h latency 4",
               product_1, lat, exp_v);
    end
    @(negedge clk);
    start_1 = 1'b0;
    n_vec++;
    if (busy_1 !== 1'b1 || ready_1 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b accept: busy=%b ready=%b, required busy=1 ready=0", busy_1, ready_1);
    end
    lat = 0;
    while (!ready_1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_v = (exp_q1.size() != 0) ? exp_q1.pop_front() : 16'hxxxx;
    n_vec++;
    if (product_1 !== exp_v || lat !== 5) begin
      n_err++;
      $display("FAIL b2b second: got product %h latency %0d, required %h latency 5",
               product_1, lat, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit saw_ready;
    exp_q0.push_back(16'hFE01);
    mode_signed = 0; multiplicand = 8'hFF; multiplier = 8'hFF; start_0 = 1'b1;
    @(negedge clk);
    start_0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_q0.delete();
    n_vec++;
    if ({busy_0, ready_0, product_0, state_0} !== 20'h0) begin
      n_err++;
      $display("FAIL abort outputs: busy=%b ready=%b product=%h state=%0d, required all 0",
               busy_0, ready_0, product_0, state_0);
    end
    saw_ready = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready_0) saw_ready = 1;
    end
    n_vec++;
    if (saw_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort ready: got a ready pulse during reset, required none");
    end
    rst = 1'b1;
    run_op(0, 0, 8'd13, 8'd11, 16'h008F, 9, "after_abort");
  endtask

  initial begin
    test_reset();
    test_full_width();
    test_early_term();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
